mem_port_arbiter: RTL and testbench

- Shares the single-ported unified Memory between the core's instruction-fetch requester and its data (load/store) requester.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- The block sequences exactly one memory transaction at a time, holds the memory enables for a fixed access latency, and returns read data to the owning requester.
- It sits between the InstructionMemory/DataMemory front-ends and Memory, replacing their direct wiring.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_grant.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  mem_arb_pkg : shared encodings and constants for mem_port_arbiter
//  Rev 1.0 : initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int LAT_CNT_W       = 3;
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = (1 << LAT_CNT_W) - 1;

    function automatic bit latency_legal(input int lat);
        return (lat >= MEM_LATENCY_MIN) && (lat <= MEM_LATENCY_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
//  mem_arb_grant : combinational instr/data grant; round-robin under MEM_ARB_RR_EN
//  Rev 1.0 : initial release
// ============================================================================
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   idle,
    input  logic   instr_valid,
    input  logic   data_valid,
    output logic   instr_ready,
    output logic   data_ready,
    output owner_t owner
);

    logic w_pick_data;

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= OWN_INSTR;
        end else if (idle && (instr_valid || data_valid)) begin
            r_last <= owner;
        end
    end

    // On a tie the requester that was not served last wins.
    assign w_pick_data = data_valid && (!instr_valid || (r_last == OWN_INSTR));
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;

    // Data access belongs to an older instruction, so it always wins a tie.
    assign w_pick_data = data_valid;
`endif

    assign owner       = w_pick_data ? OWN_DATA : OWN_INSTR;
    assign data_ready  = idle && w_pick_data;
    assign instr_ready = idle && instr_valid && !w_pick_data;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_port_arbiter : shares one memory port between fetch and load/store
//  Optional macro MEM_ARB_RR_EN selects round-robin arbitration.  Rev 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WIDTH   = 32,
    parameter int MEM_SIZE    = 256,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_req_valid,
    output logic                 instr_req_ready,
    input  logic [31:0]          instr_addr,
    output logic                 instr_rsp_valid,
    output logic [MEM_WIDTH-1:0] instr_rsp_data,
    output logic                 instr_rsp_err,
    input  logic                 data_req_valid,
    output logic                 data_req_ready,
    input  logic                 data_req_we,
    input  logic [31:0]          data_addr,
    input  logic [MEM_WIDTH-1:0] data_wdata,
    output logic                 data_rsp_valid,
    output logic [MEM_WIDTH-1:0] data_rsp_data,
    output logic                 data_rsp_err,
    output logic [31:0]          mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 busy
);

    generate
        if (!latency_legal(MEM_LATENCY)) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be within 1..7");
        end
    endgenerate

    localparam logic [LAT_CNT_W-1:0] C_LAT  = LAT_CNT_W'(MEM_LATENCY);
    localparam logic [31:0]          C_SIZE = 32'(MEM_SIZE);

    state_t                r_state;
    state_t                w_state_next;
    logic [LAT_CNT_W-1:0]  r_cnt;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic                  r_err;
    logic [MEM_WIDTH-1:0]  r_wdata;
    logic [MEM_WIDTH-1:0]  r_rdata;
    owner_t                r_owner;
    owner_t                w_grant_owner;
    logic                  w_idle;
    logic                  w_hs;

    assign w_idle = (r_state == ST_IDLE);
    // A ready is only ever raised alongside its own valid, so either ready is a handshake.
    assign w_hs   = instr_req_ready || data_req_ready;
    assign busy   = !w_idle;

    mem_arb_grant u_grant (
        .clk         (clk),
        .reset       (reset),
        .idle        (w_idle),
        .instr_valid (instr_req_valid),
        .data_valid  (data_req_valid),
        .instr_ready (instr_req_ready),
        .data_ready  (data_req_ready),
        .owner       (w_grant_owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        mem_addr        = '0;
        mem_read_en     = 1'b0;
        mem_write_en    = 1'b0;
        mem_write_val   = '0;
        instr_rsp_valid = 1'b0;
        instr_rsp_data  = '0;
        instr_rsp_err   = 1'b0;
        data_rsp_valid  = 1'b0;
        data_rsp_data   = '0;
        data_rsp_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_addr      = r_addr;
                mem_write_val = r_wdata;
                mem_read_en   = !r_we && !r_err;
                mem_write_en  = r_we && !r_err;
                if (r_cnt == C_LAT) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
                if (r_owner == OWN_DATA) begin
                    data_rsp_valid = 1'b1;
                    data_rsp_data  = r_rdata;
                    data_rsp_err   = r_err;
                end else begin
                    instr_rsp_valid = 1'b1;
                    instr_rsp_data  = r_rdata;
                    instr_rsp_err   = r_err;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_owner <= OWN_INSTR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_owner <= w_grant_owner;
                        r_cnt   <= LAT_CNT_W'(1);
                        if (w_grant_owner == OWN_DATA) begin
                            r_addr  <= data_addr;
                            r_we    <= data_req_we;
                            r_wdata <= data_wdata;
                            r_err   <= (data_addr >= C_SIZE);
                        end else begin
                            r_addr  <= instr_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_err   <= (instr_addr >= C_SIZE);
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAT) begin
                        r_rdata <= (r_we || r_err) ? '0 : mem_read_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_mem_port_arbiter : scoreboard bench with random fetch/data traffic
//  Rev 1.0 : initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int W    = 32;
    localparam int SIZE = 256;
    localparam int LAT  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_req_valid = 1'b0;
    logic          instr_req_ready;
    logic [31:0]   instr_addr = '0;
    logic          instr_rsp_valid;
    logic [W-1:0]  instr_rsp_data;
    logic          instr_rsp_err;
    logic          data_req_valid = 1'b0;
    logic          data_req_ready;
    logic          data_req_we = 1'b0;
    logic [31:0]   data_addr = '0;
    logic [W-1:0]  data_wdata = '0;
    logic          data_rsp_valid;
    logic [W-1:0]  data_rsp_data;
    logic          data_rsp_err;
    logic [31:0]   mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [W-1:0]  mem_write_val;
    logic [W-1:0]  mem_read_val;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_WIDTH   (W),
        .MEM_SIZE    (SIZE),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req_valid (instr_req_valid),
        .instr_req_ready (instr_req_ready),
        .instr_addr      (instr_addr),
        .instr_rsp_valid (instr_rsp_valid),
        .instr_rsp_data  (instr_rsp_data),
        .instr_rsp_err   (instr_rsp_err),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_we     (data_req_we),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_rsp_valid  (data_rsp_valid),
        .data_rsp_data   (data_rsp_data),
        .data_rsp_err    (data_rsp_err),
        .mem_addr        (mem_addr),
        .mem_read_en     (mem_read_en),
        .mem_write_en    (mem_write_en),
        .mem_write_val   (mem_write_val),
        .mem_read_val    (mem_read_val),
        .busy            (busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory model seen by the DUT; garbage when not read-enabled exposes stray captures.
    logic [W-1:0] phys [SIZE];
    assign mem_read_val = (mem_read_en && (mem_addr < SIZE)) ? phys[mem_addr[7:0]] : 32'hBAD0_BAD0;

    initial begin
        for (int i = 0; i < SIZE; i++) phys[i] = pat(i);
        phys[212] = 32'h2008_000A;
        forever begin
            @(posedge clk);
            if (mem_write_en && (mem_addr < SIZE)) phys[mem_addr[7:0]] = mem_write_val;
        end
    end

    // Reference: instr reads 128..255 (never stored to), data uses 0..127, so each
    // requester's expected responses depend only on its own in-order stream.
    logic [W-1:0] ref_mem [SIZE];
    logic [32:0]  exp_i [$];
    logic [32:0]  exp_d [$];
    logic [32:0]  e_mon;

    always @(negedge clk) begin
        if (reset) begin
            if (instr_rsp_valid) begin
                if (exp_i.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL instr_unexpected_rsp: got rsp data 0x%08h, expected no response", instr_rsp_data);
                end else begin
                    e_mon = exp_i.pop_front();
                    check("instr_rsp_data", instr_rsp_data, e_mon[31:0]);
                    check("instr_rsp_err", 32'(instr_rsp_err), 32'(e_mon[32]));
                end
            end
            if (data_rsp_valid) begin
                if (exp_d.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL data_unexpected_rsp: got rsp data 0x%08h, expected no response", data_rsp_data);
                end else begin
                    e_mon = exp_d.pop_front();
                    check("data_rsp_data", data_rsp_data, e_mon[31:0]);
                    check("data_rsp_err", 32'(data_rsp_err), 32'(e_mon[32]));
                end
            end
        end
    end

    // Transaction-level timing/arbitration model: handshake, LAT access cycles, one response cycle.
    bit           in_txn = 1'b0;
    int           k = 0;
    bit           last_d = 1'b0;
    bit           win_d;
    bit           t_own_d, t_we, t_err;
    logic [31:0]  t_addr, t_wdata;

    always @(negedge clk) begin
        if (!reset) begin
            in_txn = 1'b0;
            last_d = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
            check("rst_readies", {30'b0, instr_req_ready, data_req_ready}, 32'd0);
            check("rst_rsp", {30'b0, instr_rsp_valid, data_rsp_valid}, 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
        end else if (in_txn) begin
            k++;
            if (k <= LAT) begin
                check("acc_busy", 32'(busy), 32'd1);
                check("acc_read_en", 32'(mem_read_en), 32'(!t_we && !t_err));
                check("acc_write_en", 32'(mem_write_en), 32'(t_we && !t_err));
                check("acc_mem_addr", mem_addr, t_addr);
                if (t_we) check("acc_write_val", mem_write_val, t_wdata);
                check("acc_readies", {30'b0, instr_req_ready, data_req_ready}, 32'd0);
                check("acc_rsp", {30'b0, instr_rsp_valid, data_rsp_valid}, 32'd0);
            end else begin
                check("resp_busy", 32'(busy), 32'd1);
                check("resp_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
                check("resp_mem_addr", mem_addr, 32'd0);
                check("resp_readies", {30'b0, instr_req_ready, data_req_ready}, 32'd0);
                check("resp_owner", {30'b0, instr_rsp_valid, data_rsp_valid}, t_own_d ? 32'd1 : 32'd2);
                in_txn = 1'b0;
            end
        end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
            check("idle_mem_addr", mem_addr, 32'd0);
            check("idle_rsp", {30'b0, instr_rsp_valid, data_rsp_valid}, 32'd0);
            if (instr_req_valid || data_req_valid) begin
                if (instr_req_valid && data_req_valid) begin
`ifdef MEM_ARB_RR_EN
                    win_d = !last_d;
`else
                    win_d = 1'b1;
`endif
                end else begin
                    win_d = data_req_valid;
                end
                check("grant", {30'b0, instr_req_ready, data_req_ready}, win_d ? 32'd1 : 32'd2);
                in_txn  = 1'b1;
                k       = 0;
                last_d  = win_d;
                t_own_d = win_d;
                t_we    = win_d ? data_req_we : 1'b0;
                t_addr  = win_d ? data_addr : instr_addr;
                t_wdata = data_wdata;
                t_err   = (t_addr >= SIZE);
            end else begin
                check("idle_readies", {30'b0, instr_req_ready, data_req_ready}, 32'd0);
            end
        end
    end

    task automatic wait_ready(input bit is_d);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (is_d ? data_req_ready : instr_req_ready) break;
            n++;
            if (n > 400) begin
                tests++; fails++;
                $display("FAIL %s_handshake_timeout: got no ready in %0d cycles, expected a grant", is_d ? "data" : "instr", n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr_req(input logic [31:0] a);
        instr_addr      = a;
        instr_req_valid = 1'b1;
        exp_i.push_back({(a >= SIZE), (a >= SIZE) ? 32'h0 : ref_mem[a[7:0]]});
        wait_ready(1'b0);
        instr_req_valid = 1'b0;
        instr_addr      = $urandom;
    endtask

    task automatic data_req(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit track);
        data_req_we    = we;
        data_addr      = a;
        data_wdata     = wd;
        data_req_valid = 1'b1;
        if (track) begin
            if (a >= SIZE) begin
                exp_d.push_back({1'b1, 32'h0});
            end else if (we) begin
                exp_d.push_back({1'b0, 32'h0});
                ref_mem[a[7:0]] = wd;
            end else begin
                exp_d.push_back({1'b0, ref_mem[a[7:0]]});
            end
        end
        wait_ready(1'b1);
        data_req_valid = 1'b0;
        data_addr      = $urandom;
        data_wdata     = $urandom;
    endtask

    int gi, gd;
    logic [31:0] ai, ad;

    initial begin
        for (int i = 0; i < SIZE; i++) ref_mem[i] = pat(i);
        ref_mem[212] = 32'h2008_000A;

        repeat (3) @(posedge clk);
        #1;
        check("por_busy", 32'(busy), 32'd0);
        check("por_enables", {30'b0, mem_read_en, mem_write_en}, 32'd0);
        reset = 1'b1;

        instr_req(32'd212);
        data_req(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b1);
        data_req(1'b0, 32'd5, 32'h0, 1'b1);
        fork
            instr_req(32'd130);
            data_req(1'b0, 32'd10, 32'h0, 1'b1);
        join
        data_req(1'b0, 32'd300, 32'h0, 1'b1);

        // Reset lands during the first access cycle of a store: nothing may be written.
        data_req(1'b1, 32'd7, 32'h1234_5678, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_write_en", 32'(mem_write_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp", {30'b0, instr_rsp_valid, data_rsp_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        data_req(1'b0, 32'd7, 32'h0, 1'b1);

        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    gi = $urandom_range(0, 3);
                    if (gi > 0) begin
                        repeat (gi) @(posedge clk);
                        #1;
                    end
                    case ($urandom_range(0, 7))
                        0:       ai = 32'(SIZE + $urandom_range(0, 2000));
                        1:       ai = 32'hFFFF_FFF0;
                        default: ai = 32'(128 + $urandom_range(0, 127));
                    endcase
                    instr_req(ai);
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    gd = $urandom_range(0, 12);
                    if (gd > 0) begin
                        repeat (gd) @(posedge clk);
                        #1;
                    end
                    ad = ($urandom_range(0, 7) == 0) ? 32'(SIZE + $urandom_range(0, 5000))
                                                     : 32'($urandom_range(0, 127));
                    data_req(1'($urandom_range(0, 1)), ad, $urandom, 1'b1);
                end
            end
        join

        for (int n = 0; n < 50 && (exp_i.size() + exp_d.size()) > 0; n++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_i.size() + exp_d.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
